// File: rtl/npc_slv_pkg.sv
// Shared npc bus definitions: beat geometry, one-hot responder states and
// the beat-alignment helper used when latching a request address.
package npc_slv_pkg;

    localparam int BEAT_W     = 64;
    localparam int BEAT_BYTES = 8;
    localparam int ADR_W      = 32;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_GNT  = 4'b0010,
        S_RD   = 4'b0100,
        S_WR   = 4'b1000
    } npc_state_e;

    function automatic logic [ADR_W-1:0] beat_align(input logic [ADR_W-1:0] adr);
        return {adr[ADR_W-1:3], 3'b000};
    endfunction

endpackage

// File: rtl/npc_slv.sv
// npc bus responder: grants a request, then streams npc_len 64-bit beats between
// the initiator and a pipelined memory command port. All outputs are registered.
module npc_slv
    import npc_slv_pkg::*;
#(
    parameter int MAX_OUT    = 4,
    parameter int WR_ACK_GAP = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              npc_req,
    output logic              npc_gnt,
    input  logic              npc_rwn,
    input  logic [ADR_W-1:0]  npc_adr,
    input  logic [31:0]       npc_len,
    input  logic [BEAT_W-1:0] npc_wdt,
    output logic [BEAT_W-1:0] npc_rdt,
    output logic              npc_ack,
    output logic              mem_req,
    input  logic              mem_rdy,
    output logic              mem_we,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [BEAT_W-1:0] mem_wdt,
    input  logic              mem_rvld,
    input  logic [BEAT_W-1:0] mem_rdt,
    output logic              busy
);

    localparam int              GAP_W      = $clog2(WR_ACK_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(WR_ACK_GAP - 1);
    localparam logic [3:0]      MAX_OUT_L  = 4'(MAX_OUT);

    npc_state_e        state_reg,   state_next;
    logic [31:0]       len_reg,     len_next;
    logic              rwn_reg,     rwn_next;
    logic [31:0]       issued_reg,  issued_next;
    logic [31:0]       acked_reg,   acked_next;
    logic [3:0]        out_reg,     out_next;
    logic [GAP_W-1:0]  gap_reg,     gap_next;
    logic              npc_gnt_reg, npc_gnt_next;
    logic              npc_ack_reg, npc_ack_next;
    logic [BEAT_W-1:0] npc_rdt_reg, npc_rdt_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg,  mem_we_next;
    logic [ADR_W-1:0]  mem_adr_reg, mem_adr_next;
    logic [BEAT_W-1:0] mem_wdt_reg, mem_wdt_next;
    logic              busy_reg,    busy_next;
    logic              accept;

    assign accept = mem_req_reg & mem_rdy;

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        rwn_next     = rwn_reg;
        issued_next  = issued_reg + {31'd0, accept};
        acked_next   = acked_reg;
        out_next     = out_reg;
        gap_next     = (gap_reg != '0) ? gap_reg - GAP_W'(1) : '0;
        npc_gnt_next = 1'b0;
        npc_ack_next = 1'b0;
        npc_rdt_next = npc_rdt_reg;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
        mem_adr_next = accept ? mem_adr_reg + ADR_W'(BEAT_BYTES) : mem_adr_reg;
        mem_wdt_next = mem_wdt_reg;

        unique case (state_reg)
            S_IDLE: begin
                if (npc_req) begin
                    state_next   = S_GNT;
                    npc_gnt_next = 1'b1;
                    mem_adr_next = beat_align(npc_adr);
                    len_next     = npc_len;
                    rwn_next     = npc_rwn;
                    issued_next  = '0;
                    acked_next   = '0;
                    out_next     = '0;
                    gap_next     = '0;
                end
            end
            S_GNT: begin
                if (len_reg == 32'd0) begin
                    state_next = S_IDLE;
                end else if (rwn_reg) begin
                    state_next   = S_RD;
                    mem_req_next = 1'b1;
                end else begin
                    // The initiator already holds beat 0 at the head of its queue.
                    state_next   = S_WR;
                    npc_ack_next = 1'b1;
                end
            end
            S_RD: begin
                out_next     = out_reg + {3'd0, accept} - {3'd0, mem_rvld};
                acked_next   = acked_reg + {31'd0, mem_rvld};
                npc_ack_next = mem_rvld;
                if (mem_rvld) begin
                    npc_rdt_next = mem_rdt;
                end
                // A stalled command stays up; otherwise issue while budget and credits allow.
                mem_req_next = (mem_req_reg & ~mem_rdy) |
                               ((issued_next < len_reg) && (out_next < MAX_OUT_L));
                if (npc_ack_reg && (acked_reg == len_reg)) begin
                    state_next   = S_IDLE;
                    mem_req_next = 1'b0;
                    npc_ack_next = 1'b0;
                end
            end
            S_WR: begin
                acked_next = acked_reg + {31'd0, npc_ack_reg};
                if (npc_ack_reg) begin
                    gap_next     = GAP_RELOAD;
                    mem_wdt_next = npc_wdt;
                end
                // mem_wdt is the hold register; it is occupied exactly while mem_req is up.
                mem_req_next = npc_ack_reg | (mem_req_reg & ~mem_rdy);
                mem_we_next  = mem_req_next;
                npc_ack_next = ~mem_req_next && (gap_next == '0) && (acked_next < len_reg);
                if (issued_next == len_reg) begin
                    state_next   = S_IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    npc_ack_next = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            len_reg     <= '0;
            rwn_reg     <= 1'b0;
            issued_reg  <= '0;
            acked_reg   <= '0;
            out_reg     <= '0;
            gap_reg     <= '0;
            npc_gnt_reg <= 1'b0;
            npc_ack_reg <= 1'b0;
            npc_rdt_reg <= '0;
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            mem_adr_reg <= '0;
            mem_wdt_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            rwn_reg     <= rwn_next;
            issued_reg  <= issued_next;
            acked_reg   <= acked_next;
            out_reg     <= out_next;
            gap_reg     <= gap_next;
            npc_gnt_reg <= npc_gnt_next;
            npc_ack_reg <= npc_ack_next;
            npc_rdt_reg <= npc_rdt_next;
            mem_req_reg <= mem_req_next;
            mem_we_reg  <= mem_we_next;
            mem_adr_reg <= mem_adr_next;
            mem_wdt_reg <= mem_wdt_next;
            busy_reg    <= busy_next;
        end
    end

    assign npc_gnt = npc_gnt_reg;
    assign npc_ack = npc_ack_reg;
    assign npc_rdt = npc_rdt_reg;
    assign mem_req = mem_req_reg;
    assign mem_we  = mem_we_reg;
    assign mem_adr = mem_adr_reg;
    assign mem_wdt = mem_wdt_reg;
    assign busy    = busy_reg;

endmodule
